// File: rtl/fetch_decode_execute.sv
// Three-stage in-order integer core (fetch, decode/issue, execute) driving external imem, dmem and a
// reserving register file; branches resolve in execute with a 2-slot penalty and HLT freezes issue.
module fetch_decode_execute #(
  parameter int WORD  = 32,
  parameter int ADDR  = 16,
  parameter int W_RD  = 4,
  parameter int W_OPR = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  output logic             stall_o,
  output logic             v_o,
  output logic             halt_o,
  output logic [ADDR-1:0]  imem_addr_o,
  input  logic [WORD-1:0]  imem_data_i,
  output logic [ADDR-1:0]  dmem_addr_o,
  output logic             dmem_we_o,
  output logic [W_OPR-1:0] dmem_wdata_o,
  input  logic [W_OPR-1:0] dmem_rdata_i,
  output logic [W_RD-1:0]  rf_r0_o,
  output logic [W_RD-1:0]  rf_r1_o,
  input  logic [W_OPR-1:0] rf_opr0_i,
  input  logic [W_OPR-1:0] rf_opr1_i,
  input  logic             rf_reserved_i,
  output logic             rf_reserve_o,
  output logic             rf_wb_o,
  output logic [W_RD-1:0]  rf_wb_r_o,
  output logic [W_OPR-1:0] rf_result_o
);

  localparam logic [7:0] OP_ADD = 8'h00, OP_SUB = 8'h01, OP_AND = 8'h02, OP_OR  = 8'h03;
  localparam logic [7:0] OP_XOR = 8'h04, OP_ADDI = 8'h10, OP_LDI = 8'h11, OP_LD = 8'h20;
  localparam logic [7:0] OP_ST  = 8'h21, OP_CMP = 8'h30, OP_JMP = 8'h40, OP_BEQ = 8'h41;
  localparam logic [7:0] OP_BNE = 8'h42, OP_HLT = 8'hFF;

  function automatic logic writes_rd(input logic [7:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI, OP_LDI, OP_LD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [ADDR-1:0]  pc;
  logic             f_v;
  logic [WORD-1:0]  f_inst;
  logic             d_v;
  logic [7:0]       d_op;
  logic [W_RD-1:0]  d_rd;
  logic [W_OPR-1:0] d_opr0, d_opr1, d_imm;
  logic             flag_z, flag_n;

  logic [7:0]       f_op;
  logic [W_OPR-1:0] f_imm, ea, diff, result;
  logic             halting, taken, issue, fetch_adv;

  assign f_op    = f_inst[31:24];
  assign f_imm   = {{(W_OPR-16){f_inst[15]}}, f_inst[15:0]};
  assign rf_r0_o = f_inst[23:20];
  assign rf_r1_o = f_inst[19:16];

  // An HLT sitting in decode already blocks issue, so nothing behind it slips into execute.
  assign halting = halt_o | (d_v & (d_op == OP_HLT));
  assign taken   = d_v & ((d_op == OP_JMP) | ((d_op == OP_BEQ) & flag_z) |
                          ((d_op == OP_BNE) & ~flag_z));
  assign issue     = f_v & ~rf_reserved_i & ~stall_i & ~halting & ~taken;
  assign fetch_adv = ~stall_i & ~halting & (~f_v | issue);

  assign stall_o      = ~fetch_adv;
  assign rf_reserve_o = issue & writes_rd(f_op);
  assign imem_addr_o  = pc;

  assign ea           = d_opr1 + d_imm;
  assign diff         = d_opr0 - d_opr1;
  assign dmem_addr_o  = ea[ADDR-1:0];
  assign dmem_wdata_o = d_opr0;
  assign dmem_we_o    = d_v & (d_op == OP_ST) & ~stall_i;

  always_comb begin
    result = d_opr0;
    case (d_op)
      OP_ADD:  result = d_opr0 + d_opr1;
      OP_SUB:  result = diff;
      OP_AND:  result = d_opr0 & d_opr1;
      OP_OR:   result = d_opr0 | d_opr1;
      OP_XOR:  result = d_opr0 ^ d_opr1;
      OP_ADDI: result = d_opr0 + d_imm;
      OP_LDI:  result = d_imm;
      OP_LD:   result = dmem_rdata_i;
      default: result = d_opr0;
    endcase
  end

  // Fetch: a taken branch redirects even while the downstream is stalled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= '0;
      f_v    <= 1'b0;
      f_inst <= '0;
    end else if (taken) begin
      pc  <= d_imm[ADDR-1:0];
      f_v <= 1'b0;
    end else if (fetch_adv) begin
      pc     <= pc + ADDR'(1);
      f_v    <= 1'b1;
      f_inst <= imem_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_v    <= 1'b0;
      d_op   <= '0;
      d_rd   <= '0;
      d_opr0 <= '0;
      d_opr1 <= '0;
      d_imm  <= '0;
    end else if (taken) begin
      d_v <= 1'b0;
    end else if (issue) begin
      d_v    <= 1'b1;
      d_op   <= f_op;
      d_rd   <= rf_r0_o;
      d_opr0 <= rf_opr0_i;
      d_opr1 <= rf_opr1_i;
      d_imm  <= f_imm;
    end else if (!stall_i) begin
      d_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_o         <= 1'b0;
      rf_wb_o     <= 1'b0;
      rf_wb_r_o   <= '0;
      rf_result_o <= '0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      halt_o      <= 1'b0;
    end else begin
      if (!stall_i) begin
        v_o         <= d_v;
        rf_wb_o     <= d_v & writes_rd(d_op);
        rf_wb_r_o   <= d_rd;
        rf_result_o <= result;
        if (d_v && d_op == OP_CMP) begin
          flag_z <= (diff == '0);
          flag_n <= diff[W_OPR-1];
        end
      end
      if (d_v && d_op == OP_HLT) halt_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Scoreboard bench: expected write-backs are queued per program, a monitor pops them on each fresh rf_wb_o.
module tb_fetch_decode_execute;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall_i = 1'b0;
  logic        stall_o, v_o, halt_o, dmem_we_o, rf_reserved, rf_reserve_o, rf_wb_o;
  logic [15:0] imem_addr_o, dmem_addr_o;
  logic [31:0] imem_data, dmem_wdata_o, dmem_rdata, rf_opr0, rf_opr1, rf_result_o;
  logic [3:0]  rf_r0_o, rf_r1_o, rf_wb_r_o;

  always #5 clk = ~clk;

  fetch_decode_execute dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .stall_o(stall_o), .v_o(v_o), .halt_o(halt_o),
    .imem_addr_o(imem_addr_o), .imem_data_i(imem_data),
    .dmem_addr_o(dmem_addr_o), .dmem_we_o(dmem_we_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rdata_i(dmem_rdata), .rf_r0_o(rf_r0_o), .rf_r1_o(rf_r1_o),
    .rf_opr0_i(rf_opr0), .rf_opr1_i(rf_opr1), .rf_reserved_i(rf_reserved),
    .rf_reserve_o(rf_reserve_o), .rf_wb_o(rf_wb_o), .rf_wb_r_o(rf_wb_r_o), .rf_result_o(rf_result_o)
  );

  logic [31:0] imem [64];
  logic [31:0] dmem [64];
  logic [31:0] rf   [16];
  logic [15:0] res;

  assign imem_data   = imem[imem_addr_o[5:0]];
  assign dmem_rdata  = dmem[dmem_addr_o[5:0]];
  assign rf_opr0     = rf[rf_r0_o];
  assign rf_opr1     = rf[rf_r1_o];
  assign rf_reserved = res[rf_r0_o] | res[rf_r1_o];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
    end else if (dmem_we_o) begin
      dmem[dmem_addr_o[5:0]] <= dmem_wdata_o;
    end
  end

  // Reservation set is applied after the clear so a same-edge reserve wins.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
      res <= 16'd0;
    end else begin
      if (rf_wb_o) begin
        rf[rf_wb_r_o]  <= rf_result_o;
        res[rf_wb_r_o] <= 1'b0;
      end
      if (rf_reserve_o) res[rf_r0_o] <= 1'b1;
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_seen = 0;
  logic [35:0] exp_q [$];
  logic [35:0] e;
  logic        fresh = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, want);
    end
  endtask

  always @(posedge clk) fresh <= ~stall_i;

  always @(negedge clk) begin
    if (reset) begin
      if (!halt_o && stall_o) stall_seen++;
      if (fresh && rf_wb_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wb_unexpected: got r%0d=%08h expected no write", rf_wb_r_o, rf_result_o);
        end else begin
          e = exp_q.pop_front();
          check("wb_reg", {28'd0, rf_wb_r_o}, {28'd0, e[35:32]});
          check("wb_val", rf_result_o, e[31:0]);
        end
      end
    end
  end

  task automatic push(input logic [3:0] r, input logic [31:0] v);
    exp_q.push_back({r, v});
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
    case (p)
      1: begin
        imem[0] = 32'h1110_0005; imem[1] = 32'h1120_0007; imem[2] = 32'h0012_0000;
      end
      2: begin
        imem[0] = 32'h1130_1234; imem[1] = 32'h2130_0004; imem[2] = 32'h2040_0004;
      end
      3: begin
        imem[0] = 32'h1110_0003; imem[1] = 32'h1120_0003; imem[2] = 32'h3012_0000;
        imem[3] = 32'h4100_0005; imem[4] = 32'h1150_0001; imem[5] = 32'h1160_0002;
      end
      default: begin
        imem[0] = 32'h1110_FFFF; imem[1] = 32'h1010_0001;
      end
    endcase
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_pc"},      {16'd0, imem_addr_o}, 32'd0);
    check({nm, "_halt"},    {31'd0, halt_o}, 32'd0);
    check({nm, "_v"},       {31'd0, v_o}, 32'd0);
    check({nm, "_wb"},      {31'd0, rf_wb_o}, 32'd0);
    check({nm, "_we"},      {31'd0, dmem_we_o}, 32'd0);
    check({nm, "_reserve"}, {31'd0, rf_reserve_o}, 32'd0);
    check({nm, "_stall"},   {31'd0, stall_o}, 32'd0);
    check({nm, "_result"},  rf_result_o, 32'd0);
  endtask

  task automatic start_prog(input int p);
    @(negedge clk);
    #2 reset = 1'b0;
    stall_i = 1'b0;
    #1 check_reset_outs("rst");
    load_prog(p);
    exp_q.delete();
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  task automatic finish_prog(input string nm);
    int cyc = 0;
    while (!halt_o && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_halted"}, {31'd0, halt_o}, 32'd1);
    repeat (4) @(negedge clk);
    check({nm, "_drained"}, exp_q.size(), 32'd0);
  endtask

  logic        sv_v, sv_wb;
  logic [15:0] sv_pc;
  int          s0;

  initial begin
    start_prog(1);
    push(4'd1, 32'd5); push(4'd2, 32'd7); push(4'd1, 32'h0000_000C);
    s0 = stall_seen;
    finish_prog("p1");
    check("p1_r1", rf[1], 32'h0000_000C);
    check("p1_add_waited", {31'd0, stall_seen > s0}, 32'd1);

    start_prog(2);
    push(4'd3, 32'h1234); push(4'd4, 32'h1234);
    finish_prog("p2");
    check("p2_dmem4", dmem[4], 32'h0000_1234);
    check("p2_r4", rf[4], 32'h0000_1234);

    start_prog(3);
    push(4'd1, 32'd3); push(4'd2, 32'd3); push(4'd6, 32'd2);
    finish_prog("p3");
    check("p3_r5", rf[5], 32'd0);
    check("p3_r6", rf[6], 32'd2);

    start_prog(4);
    push(4'd1, 32'hFFFF_FFFF); push(4'd1, 32'd0);
    finish_prog("p4");
    check("p4_r1", rf[1], 32'd0);

    start_prog(2);
    push(4'd3, 32'h1234); push(4'd4, 32'h1234);
    repeat (5) @(negedge clk);
    sv_v = v_o; sv_wb = rf_wb_o; sv_pc = imem_addr_o;
    stall_i = 1'b1;
    #1 check("stall_we0", {31'd0, dmem_we_o}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_v",  {31'd0, v_o}, {31'd0, sv_v});
      check("stall_wb", {31'd0, rf_wb_o}, {31'd0, sv_wb});
      check("stall_pc", {16'd0, imem_addr_o}, {16'd0, sv_pc});
      check("stall_we", {31'd0, dmem_we_o}, 32'd0);
    end
    stall_i = 1'b0;
    finish_prog("p5");
    check("p5_dmem4", dmem[4], 32'h0000_1234);
    check("p5_r4", rf[4], 32'h0000_1234);

    start_prog(1);
    push(4'd1, 32'd5); push(4'd2, 32'd7); push(4'd1, 32'h0000_000C);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outs("midrst");
    exp_q.delete();
    push(4'd1, 32'd5); push(4'd2, 32'd7); push(4'd1, 32'h0000_000C);
    @(negedge clk);
    #2 reset = 1'b1;
    finish_prog("p6");
    check("p6_r1", rf[1], 32'h0000_000C);
    check("p6_r2", rf[2], 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_decode_execute.md
# fetch_decode_execute

Three-stage in-order integer pipeline core: fetch, decode and execute. It sits between an external instruction memory, an external data memory and an external 16-entry register file with a write-reservation scoreboard. Branches resolve in execute. HLT freezes the core until reset.

## Interface
Parameters:
- WORD, 32, instruction width.
- ADDR, 16, instruction/data address width (word addresses).
- W_RD, 4, register index width.
- W_OPR, 32, operand/result width.

Ports:
- clk  in  1  clock, all flops rising edge.
- reset  in  1  asynchronous, active-low.
- stall_i  in  1  downstream hold; execute output frozen while 1.
- stall_o  out  1  fetch not advancing this cycle.
- v_o  out  1  execute output valid.
- halt_o  out  1  HLT reached decode output; sticky until reset.
- imem_addr_o  out  ADDR  = PC; imem_data_i  in  WORD  combinational read of imem[imem_addr_o].
- dmem_addr_o  out  ADDR; dmem_we_o  out  1; dmem_wdata_o  out  W_OPR; dmem_rdata_i  in  W_OPR.
  - Data memory reads combinationally; it writes at the clock edge when dmem_we_o=1.
- rf_r0_o, rf_r1_o  out  W_RD  read indices (rd, rs fields of the instruction in fetch output).
- rf_opr0_i, rf_opr1_i  in  W_OPR  combinational register values.
- rf_reserved_i  in  1  rf_r0_o or rf_r1_o has a pending write.
- rf_reserve_o  out  1  reserve register rf_r0_o this edge.
- rf_wb_o  out  1; rf_wb_r_o  out  W_RD; rf_result_o  out  W_OPR.
  - Write-back: writes the result and clears the reservation.

## Operation
Instruction format: op=[31:24], rd=[23:20], rs=[19:16], imm=[15:0]. imm is sign-extended to W_OPR. ea=rs+imm. Unlisted opcodes execute as NOP.

| op | mnemonic | effect | writes rd |
|---|---|---|---|
| 00 | ADD | rd=rd+rs | yes |
| 01 | SUB | rd=rd−rs | yes |
| 02 | AND | rd=rd&rs | yes |
| 03 | OR | rd=rd\|rs | yes |
| 04 | XOR | rd=rd^rs | yes |
| 10 | ADDI | rd=rd+imm | yes |
| 11 | LDI | rd=imm | yes |
| 20 | LD | rd=dmem[ea[ADDR-1:0]] | yes |
| 21 | ST | dmem[ea]=rd | no |
| 30 | CMP | flags Z=(rd−rs==0), N=sign(rd−rs) | no |
| 40 | JMP | pc=imm[ADDR-1:0] | no |
| 41 | BEQ | jump if Z | no |
| 42 | BNE | jump if !Z | no |
| FF | HLT | halt | no |

Arithmetic is modulo 2^W_OPR. Flags are changed only by CMP. Flags reset to 0.

Pipeline stages:
- **Fetch:** PC register, reset 0. Each non-stalled edge it latches inst=imem_data_i and pc, sets v=1, and PC+1.
- **Decode:**
  - Drives rf_r0_o/rf_r1_o from the fetch output.
  - Issues (registers operands, imm, op, rd, pc; v_de=1) only when the fetch output is valid, !rf_reserved_i, execute is not stalled, and the core is not halted.
  - On issue of a yes-writes-rd op it pulses rf_reserve_o for that edge.
  - When it cannot issue, it stalls fetch; v_de=0 unless held by an execute stall.
- **Execute:**
  - Combinational on the decode registers.
  - Data memory: dmem_we_o=v_de&ST, dmem_addr_o=ea, dmem_wdata_o=rd.
  - Result and write-back: the result is registered to rf_result_o; rf_wb_o/v_o register at the edge.
  - Branch: branch taken is combinational in the cycle v_de holds JMP or a true BEQ/BNE.
- **Taken branch:**
  - PC←target at the next edge.
  - Fetch output and decode output are invalidated at that edge (2-cycle penalty).
  - Branch priority beats stall.
- **HLT:**
  - When HLT is valid at decode output, halt_o←1.
  - After that, fetch and decode stop; instructions already in execute complete.

Stalls:
- stall_i=1 holds execute outputs and v_o.
- The stall propagates back, so decode and fetch hold.
- dmem_we_o is suppressed while stalled.
- stall_o = fetch hold (decode stall, stall_i, or halt).

## Timing
- All outputs are 0 after reset, and PC=0.
- Latency: an instruction fetched at edge n issues at n+1 and writes back at n+2. rf_wb_o is valid in the cycle after n+2.
- A dependent instruction waits in decode until its source reservation is cleared by the write-back; the register file then forwards.
- Reset mid-operation clears all valid bits, flags, halt_o and PC asynchronously.

## Test plan
- Program LDI r1,5; LDI r2,7; ADD r1,r2; HLT.
  - Required: r1=0000000C and halt_o=1.
  - Required: the ADD stalls in decode while r1/r2 are reserved; no wrong value is written.
- Program LDI r3,0x1234; ST r3,[r0+4]; LD r4,[r0+4].
  - Required: dmem[4]=00001234 and r4=00001234.
- Program LDI r1,3; LDI r2,3; CMP r1,r2; BEQ +target; LDI r5,1 (skipped); target: LDI r6,2; HLT.
  - Required: r5=0 and r6=2; the 2 wrong-path slots never write.
- Program LDI r1,−1; ADDI r1,1.
  - Required: r1=00000000 (wrap-around).
- Hold stall_i=1 for 3 cycles mid-program.
  - Required: v_o, rf_wb_o and PC are frozen and no dmem write occurs.
  - Required: final registers match the unstalled run.
- Drop reset to 0 mid-program, then release it.
  - Required: PC=0, halt_o=0, outputs 0, and the program reruns identically.
